// File: rtl/rv_clint_pkg.sv
// rv_clint_pkg: CLINT register offsets, MTIME width, reset constants and
// the shared decode / byte-merge helpers used by rv_clint and rv_clint_timer.
package rv_clint_pkg;

   localparam int unsigned MTIME_W = 64;

   localparam logic [15:0] CLINT_MSIP        = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
   localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
   localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
   localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

   localparam logic [MTIME_W-1:0] MTIMECMP_RST = '1;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_MSIP,
      REG_CMP_LO,
      REG_CMP_HI,
      REG_MTIME_LO,
      REG_MTIME_HI
   } reg_sel_e;

   // Misaligned offsets never hit a register.
   function automatic reg_sel_e decode_addr(input logic [15:0] addr);
      reg_sel_e sel;
      sel = REG_NONE;
      if (addr[1:0] == 2'b00) begin
         case (addr)
            CLINT_MSIP:        sel = REG_MSIP;
            CLINT_MTIMECMP_LO: sel = REG_CMP_LO;
            CLINT_MTIMECMP_HI: sel = REG_CMP_HI;
            CLINT_MTIME_LO:    sel = REG_MTIME_LO;
            CLINT_MTIME_HI:    sel = REG_MTIME_HI;
            default:           sel = REG_NONE;
         endcase
      end
      return sel;
   endfunction

   // Replace only the bytes whose enable is set.
   function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/rv_clint_timer.sv
// rv_clint_timer: prescaler producing a tick every TICK_DIV cycles and the
// 64-bit MTIME register with a byte-masked write port. A write to either
// half suppresses that cycle's increment for the whole 64 bits.
module rv_clint_timer
   import rv_clint_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               we_lo_i,
   input  logic               we_hi_i,
   input  logic [3:0]         be_i,
   input  logic [31:0]        wdata_i,
   output logic               tick_o,
   output logic [MTIME_W-1:0] mtime_o,
   output logic [MTIME_W-1:0] mtime_next_o
);

   localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

   logic [15:0]        presc_q, presc_d;
   logic [MTIME_W-1:0] mtime_q, mtime_d;
   logic               tick;

   // Next-state for prescaler and MTIME; writes win over the tick.
   always_comb begin
      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      mtime_d = mtime_q;
      if (we_lo_i || we_hi_i) begin
         if (we_lo_i) mtime_d[31:0]  = merge_be(mtime_q[31:0], wdata_i, be_i);
         if (we_hi_i) mtime_d[63:32] = merge_be(mtime_q[63:32], wdata_i, be_i);
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
   end

   // Prescaler and MTIME state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         presc_q <= 16'd0;
         mtime_q <= '0;
      end else begin
         presc_q <= presc_d;
         mtime_q <= mtime_d;
      end
   end

   assign tick_o       = tick;
   assign mtime_o      = mtime_q;
   assign mtime_next_o = mtime_d;

endmodule

// File: rtl/rv_clint.sv
// rv_clint: core-local interrupt controller. Bus decode, MSIP, MTIMECMP,
// timer compare and the single-outstanding response channel.
// Handshake: a request is taken when req_valid_i & req_ready_o, with
// req_ready_o = ~rsp_valid_o; the response is held until rsp_ready_i.
// Build option RV_CLINT_BUS_ERR_EN: unmapped/misaligned accesses answer
// with rsp_err_o=1 (otherwise rsp_err_o is constant 0).
module rv_clint
   import rv_clint_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1,
   parameter int unsigned ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [3:0]        req_be_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              soft_irq_o,
   output logic              timer_irq_o
);

   logic               msip_q, msip_d;
   logic [MTIME_W-1:0] cmp_q, cmp_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;
   logic               soft_irq_q, soft_irq_d;
   logic               timer_irq_q, timer_irq_d;

   reg_sel_e           sel;
   logic               accept, wr;
   logic [31:0]        rd_mux;
   logic               tick;
   logic [MTIME_W-1:0] mtime, mtime_next;
   logic               unused_ok;

   assign unused_ok = ^{tick, req_addr_i};

   rv_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
      .clk          (clk),
      .rstn         (rstn),
      .we_lo_i      (wr && (sel == REG_MTIME_LO)),
      .we_hi_i      (wr && (sel == REG_MTIME_HI)),
      .be_i         (req_be_i),
      .wdata_i      (req_wdata_i),
      .tick_o       (tick),
      .mtime_o      (mtime),
      .mtime_next_o (mtime_next)
   );

   // Decode, register writes, read mux, response and interrupt next-state.
   always_comb begin
      sel    = decode_addr(req_addr_i[15:0]);
      accept = req_valid_i & ~rsp_valid_q;
      wr     = accept & req_we_i;

      msip_d = msip_q;
      cmp_d  = cmp_q;
      if (wr && (sel == REG_MSIP) && req_be_i[0]) msip_d = req_wdata_i[0];
      if (wr && (sel == REG_CMP_LO)) cmp_d[31:0]  = merge_be(cmp_q[31:0], req_wdata_i, req_be_i);
      if (wr && (sel == REG_CMP_HI)) cmp_d[63:32] = merge_be(cmp_q[63:32], req_wdata_i, req_be_i);

      case (sel)
         REG_MSIP:     rd_mux = {31'd0, msip_q};
         REG_CMP_LO:   rd_mux = cmp_q[31:0];
         REG_CMP_HI:   rd_mux = cmp_q[63:32];
         REG_MTIME_LO: rd_mux = mtime[31:0];
         REG_MTIME_HI: rd_mux = mtime[63:32];
         default:      rd_mux = 32'd0;
      endcase

      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rdata_d     = req_we_i ? 32'd0 : rd_mux;
`ifdef RV_CLINT_BUS_ERR_EN
         err_d       = (sel == REG_NONE);
`else
         err_d       = 1'b0;
`endif
      end else if (rsp_valid_q && rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end

      soft_irq_d  = msip_q;
      timer_irq_d = (mtime_next >= cmp_d);
   end

   // Architectural registers, response channel and interrupt outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         msip_q      <= 1'b0;
         cmp_q       <= MTIMECMP_RST;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
         soft_irq_q  <= 1'b0;
         timer_irq_q <= 1'b0;
      end else begin
         msip_q      <= msip_d;
         cmp_q       <= cmp_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         soft_irq_q  <= soft_irq_d;
         timer_irq_q <= timer_irq_d;
      end
   end

   assign req_ready_o = ~rsp_valid_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
`ifdef RV_CLINT_BUS_ERR_EN
   assign rsp_err_o   = err_q;
`else
   assign rsp_err_o   = 1'b0;
`endif
   assign soft_irq_o  = soft_irq_q;
   assign timer_irq_o = timer_irq_q;

endmodule

// File: tb/tb_rv_clint.sv
// tb_rv_clint: directed bench for rv_clint (TICK_DIV=1, ADDR_W=16).
// Expected bus error flag follows RV_CLINT_BUS_ERR_EN.
module tb_rv_clint;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [15:0] req_addr_i = 16'd0;
   logic [3:0]  req_be_i = 4'd0;
   logic [31:0] req_wdata_i = 32'd0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        soft_irq_o;
   logic        timer_irq_o;

   int errors = 0;
   int checks = 0;

`ifdef RV_CLINT_BUS_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   rv_clint #(.TICK_DIV(1), .ADDR_W(16)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_be_i    (req_be_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .soft_irq_o  (soft_irq_o),
      .timer_irq_o (timer_irq_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200us");
      $fatal(1, "watchdog expired");
   end

   // Reference MTIME: +1 every cycle unless the bench writes an MTIME half.
   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   logic [63:0] mtime_m;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) mtime_m <= 64'd0;
      else if (req_valid_i && req_we_i && req_addr_i == 16'hBFF8)
         mtime_m <= {mtime_m[63:32], merge(mtime_m[31:0], req_wdata_i, req_be_i)};
      else if (req_valid_i && req_we_i && req_addr_i == 16'hBFFC)
         mtime_m <= {merge(mtime_m[63:32], req_wdata_i, req_be_i), mtime_m[31:0]};
      else mtime_m <= mtime_m + 64'd1;
   end

   // scoreboard check
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver: one access with rsp_ready_i=1; returns at the negedge after accept
   logic [31:0] rd;
   logic        er;
   logic [63:0] macc;

   task automatic access(input logic we, input logic [15:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
      @(negedge clk);
      check("req_ready_idle", req_ready_o, 1'b1);
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_be_i    = be;
      req_wdata_i = wd;
      rsp_ready_i = 1'b1;
      macc        = mtime_m;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      req_we_i    = 1'b0;
      check("rsp_valid_after_accept", rsp_valid_o, 1'b1);
      rd = rsp_rdata_o;
      er = rsp_err_o;
   endtask

   logic [31:0] hold;
   logic        found;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready_o, 1'b1);
      check("rst_rsp_valid", rsp_valid_o, 1'b0);
      check("rst_rdata", rsp_rdata_o, 32'd0);
      check("rst_err", rsp_err_o, 1'b0);
      check("rst_soft", soft_irq_o, 1'b0);
      check("rst_timer", timer_irq_o, 1'b0);
      rstn = 1'b1;

      // MTIME counts from 0 with no access
      access(1'b0, 16'hBFF8, 4'hF, 32'd0);
      check("mtime_first", rd, 32'd1);
      access(1'b0, 16'hBFF8, 4'hF, 32'd0);
      check("mtime_second", rd, 32'd3);
      access(1'b0, 16'hBFFC, 4'hF, 32'd0);
      check("mtime_hi_zero", rd, 32'd0);
      access(1'b0, 16'h4004, 4'hF, 32'd0);
      check("cmp_hi_reset", rd, 32'hFFFF_FFFF);
      check("cmp_hi_err", er, 1'b0);
      access(1'b0, 16'h4000, 4'hF, 32'd0);
      check("cmp_lo_reset", rd, 32'hFFFF_FFFF);
      check("timer_idle", timer_irq_o, 1'b0);
      check("soft_idle", soft_irq_o, 1'b0);

      // MSIP / soft interrupt
      access(1'b1, 16'h0000, 4'b0001, 32'd1);
      check("msip_wr_rdata_zero", rd, 32'd0);
      check("soft_one_cycle_after", soft_irq_o, 1'b0);
      @(negedge clk);
      check("soft_two_cycles_after", soft_irq_o, 1'b1);
      access(1'b0, 16'h0000, 4'hF, 32'd0);
      check("msip_read_one", rd, 32'd1);
      access(1'b1, 16'h0000, 4'b0001, 32'd0);
      @(negedge clk);
      check("soft_cleared", soft_irq_o, 1'b0);
      access(1'b1, 16'h0000, 4'b0010, 32'hFFFF_FFFF);
      @(negedge clk);
      check("soft_be1_ignored", soft_irq_o, 1'b0);
      access(1'b1, 16'h0000, 4'b0001, 32'hFFFF_FFFF);
      access(1'b0, 16'h0000, 4'hF, 32'd0);
      check("msip_upper_bits_zero", rd, 32'd1);
      access(1'b1, 16'h0000, 4'b0001, 32'd0);
      access(1'b0, 16'h0000, 4'hF, 32'd0);
      check("msip_read_zero", rd, 32'd0);

      // timer compare at 100
      access(1'b1, 16'h4004, 4'hF, 32'd0);
      access(1'b1, 16'h4000, 4'hF, 32'd100);
      check("timer_below_cmp", timer_irq_o, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (mtime_m == 64'd99) found = 1'b1;
      end
      check("mtime_reach_99", found, 1'b1);
      check("timer_at_99", timer_irq_o, 1'b0);
      @(negedge clk);
      check("timer_at_100", timer_irq_o, 1'b1);
      repeat (4) @(negedge clk);
      check("timer_level_held", timer_irq_o, 1'b1);
      access(1'b1, 16'h4004, 4'hF, 32'd1);
      check("timer_clear_cmp_hi", timer_irq_o, 1'b0);

      // MTIME wrap
      access(1'b1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF);
      access(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF);
      check("timer_mtime_huge", timer_irq_o, 1'b1);
      access(1'b0, 16'hBFF8, 4'hF, 32'd0);
      check("mtime_wrap_lo", rd, 32'd0);
      access(1'b0, 16'hBFFC, 4'hF, 32'd0);
      check("mtime_wrap_hi", rd, 32'd0);
      check("timer_after_wrap", timer_irq_o, 1'b0);

      // write coinciding with a tick: no extra increment
      access(1'b1, 16'hBFF8, 4'hF, 32'h0000_1000);
      access(1'b0, 16'hBFF8, 4'hF, 32'd0);
      check("mtime_write_wins", rd, 32'h0000_1001);
      access(1'b1, 16'hBFF8, 4'b1100, 32'hDEAD_0000);
      access(1'b0, 16'hBFF8, 4'hF, 32'd0);
      check("mtime_byte_mask", rd, macc[31:0]);
      check("mtime_byte_mask_top", rd[31:16], 16'hDEAD);

      // response back-pressure
      @(negedge clk);
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_addr_i  = 16'hBFF8;
      req_be_i    = 4'hF;
      rsp_ready_i = 1'b0;
      macc        = mtime_m;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      check("stall_valid", rsp_valid_o, 1'b1);
      hold = rsp_rdata_o;
      check("stall_rdata", hold, macc[31:0]);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid_held", rsp_valid_o, 1'b1);
         check("stall_rdata_held", rsp_rdata_o, macc[31:0]);
         check("stall_req_ready", req_ready_o, 1'b0);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      check("release_valid_drop", rsp_valid_o, 1'b0);
      check("release_req_ready", req_ready_o, 1'b1);
      req_valid_i = 1'b1;
      req_addr_i  = 16'h4004;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      check("next_req_valid", rsp_valid_o, 1'b1);
      check("next_req_rdata", rsp_rdata_o, 32'd1);

      // unmapped and misaligned
      access(1'b0, 16'h1234, 4'hF, 32'd0);
      check("unmapped_rdata", rd, 32'd0);
      check("unmapped_err", er, EXP_ERR);
      access(1'b1, 16'h1234, 4'hF, 32'hFFFF_FFFF);
      check("unmapped_wr_err", er, EXP_ERR);
      access(1'b0, 16'h4001, 4'hF, 32'd0);
      check("misaligned_rdata", rd, 32'd0);
      check("misaligned_err", er, EXP_ERR);
      access(1'b1, 16'h4002, 4'hF, 32'd0);
      access(1'b1, 16'h0001, 4'hF, 32'hFFFF_FFFF);
      access(1'b0, 16'h0000, 4'hF, 32'd0);
      check("unmapped_msip_kept", rd, 32'd0);
      check("unmapped_err_clear", er, 1'b0);
      access(1'b0, 16'h4000, 4'hF, 32'd0);
      check("unmapped_cmp_lo_kept", rd, 32'd100);
      access(1'b0, 16'h4004, 4'hF, 32'd0);
      check("unmapped_cmp_hi_kept", rd, 32'd1);
      access(1'b0, 16'hBFF8, 4'hF, 32'd0);
      check("mtime_final", rd, macc[31:0]);
      check("soft_final", soft_irq_o, 1'b0);

      // report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
